// File: rtl/ysyx_23060124_axi_lite_sram.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060124_axi_lite_sram
// Brief    : AXI-Lite slave backed by a word-addressed SRAM array. It has
//            independent read and write channels, and each response is delayed
//            by a programmable latency.
// Revision : 1.0
// ============================================================================
module ysyx_23060124_axi_lite_sram #(
    parameter int unsigned             ADDR_WIDTH  = 32,
    parameter int unsigned             DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned             DEPTH_WORDS = 32768,
    parameter int unsigned             RD_LAT      = 1,
    parameter int unsigned             WR_LAT      = 1,
    parameter string                   INIT_FILE   = ""
) (
    input  logic                      AXI_ACLK,
    input  logic                      AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH  = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(64'(DEPTH_WORDS) * 64'd4);
    localparam logic [3:0] RD_CNT_INIT = 4'(RD_LAT);
    localparam logic [3:0] WR_CNT_INIT = 4'(WR_LAT);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >= BASE_ADDR) && ({1'b0, addr - BASE_ADDR} < SPAN);
    endfunction

    function automatic logic [IDX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_WIDTH'((addr - BASE_ADDR) >> 2);
    endfunction

    // ------------------------------------------------------------------ read
    r_state_t              r_state_q, r_state_d;
    logic [3:0]            r_cnt_q, r_cnt_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    // R_WAIT always takes at least one cycle. That cycle samples the array,
    // so RVALID rises RD_LAT+1 edges after the AR handshake.
    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        araddr_d  = araddr_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (S_AXI_ARVALID && arready_q) begin
                    araddr_d  = S_AXI_ARADDR;
                    r_cnt_d   = RD_CNT_INIT;
                    arready_d = 1'b0;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_cnt_q == 4'd0) begin
                    rvalid_d  = 1'b1;
                    r_state_d = R_RESP;
                    if (addr_in_range(araddr_q)) begin
                        rdata_d = mem[addr_index(araddr_q)];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_DECERR;
                    end
                end else begin
                    r_cnt_d = r_cnt_q - 4'd1;
                end
            end
            R_RESP: begin
                if (S_AXI_RREADY) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            araddr_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            araddr_q  <= araddr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // ----------------------------------------------------------------- write
    w_state_t              w_state_q, w_state_d;
    logic [3:0]            w_cnt_q, w_cnt_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  aw_got_q, aw_got_d;
    logic                  w_got_q, w_got_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  mem_we;

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (S_AXI_AWVALID && awready_q) begin
                    awaddr_d = S_AXI_AWADDR;
                    aw_got_d = 1'b1;
                end
                if (S_AXI_WVALID && wready_q) begin
                    wdata_d = S_AXI_WDATA;
                    wstrb_d = S_AXI_WSTRB;
                    w_got_d = 1'b1;
                end
                awready_d = !aw_got_d;
                wready_d  = !w_got_d;
                if (aw_got_d && w_got_d) begin
                    w_cnt_d   = WR_CNT_INIT;
                    w_state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (w_cnt_q == 4'd0) begin
                    mem_we    = addr_in_range(awaddr_q);
                    bresp_d   = addr_in_range(awaddr_q) ? RESP_OKAY : RESP_DECERR;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                end else begin
                    w_cnt_d = w_cnt_q - 4'd1;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // The array has no reset. mem_we comes from the reset-cleared write FSM,
    // so a reset in the middle of a transaction never commits a partial write.
    always_ff @(posedge AXI_ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb_q[b]) begin
                    mem[addr_index(awaddr_q)][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;

endmodule
`default_nettype wire
